// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte collector: FSM state encodings and
// the default word width.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    typedef enum logic [0:0] {
        STATE_IDLE    = IDLE,
        STATE_COLLECT = COLLECT
    } state_e;

endpackage

// File: rtl/serial_byte_collector_if.sv
// Output word stream of the serial byte collector: data/valid from the
// collector, ready back from the consumer.
interface serial_byte_collector_if
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/serial_byte_collector.sv
// Collects LSB-first serial bits into WIDTH-bit words and hands each word out
// over a valid/ready stream, flagging dropped words and aborted frames.
module serial_byte_collector
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                           Clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    input  logic                           clr_overrun,
    output logic                           busy,
    output logic                           overrun,
    output logic                           frame_abort,
    serial_byte_collector_if.master        out_if
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [0:0]       state_r;
    logic [0:0]       state_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] out_data_s;
    logic             out_valid_r;
    logic             out_valid_s;
    logic             overrun_r;
    logic             overrun_s;
    logic             frame_abort_r;
    logic             abort_s;
    logic             busy_r;
    logic             complete_s;
    logic             drop_s;
    logic             unused_shreg_lsb_s;

    // The oldest bit falls off the end of the shift and is never observed.
    assign unused_shreg_lsb_s = shreg_r[0];
    assign shifted_s          = {bit_in, shreg_r[WIDTH-1:1]};

    // Frame sequencing: restart, bit shifting and word completion.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        shreg_s    = shreg_r;
        complete_s = 1'b0;
        abort_s    = 1'b0;
        if (start) begin
            // A restart always wins, even over a bit that would finish the word.
            state_s = COLLECT;
            abort_s = (state_r == COLLECT) && (count_r != CNT_ZERO);
            if (bit_valid) begin
                shreg_s = shifted_s;
                count_s = CNT_ONE;
            end else begin
                count_s = CNT_ZERO;
            end
        end else if ((state_r == COLLECT) && bit_valid) begin
            shreg_s = shifted_s;
            if (count_r == LAST_BIT) begin
                complete_s = 1'b1;
                state_s    = IDLE;
                count_s    = CNT_ZERO;
            end else begin
                count_s = count_r + CNT_ONE;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Output stream handoff and the sticky overrun flag.
    always_comb begin
        out_data_s  = out_data_r;
        out_valid_s = out_valid_r;
        drop_s      = 1'b0;
        if (complete_s) begin
            if (!out_valid_r || out_if.out_ready) begin
                out_data_s  = shifted_s;
                out_valid_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else if (out_valid_r && out_if.out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end

        if (drop_s) begin
            overrun_s = 1'b1;
        end else if (clr_overrun) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_r       <= IDLE;
            count_r       <= CNT_ZERO;
            shreg_r       <= {WIDTH{1'b0}};
            out_data_r    <= {WIDTH{1'b0}};
            out_valid_r   <= 1'b0;
            overrun_r     <= 1'b0;
            frame_abort_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            shreg_r       <= shreg_s;
            out_data_r    <= out_data_s;
            out_valid_r   <= out_valid_s;
            overrun_r     <= overrun_s;
            frame_abort_r <= abort_s;
            busy_r        <= (state_s == COLLECT);
        end
    end

    assign out_if.out_data  = out_data_r;
    assign out_if.out_valid = out_valid_r;
    assign overrun          = overrun_r;
    assign frame_abort      = frame_abort_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed bench for serial_byte_collector: hand-computed words, handshake,
// overrun, restart and reset scenarios.
module tb_serial_byte_collector;

    logic Clock;
    logic reset;
    logic start;
    logic bit_in;
    logic bit_valid;
    logic clr_overrun;
    logic busy;
    logic overrun;
    logic frame_abort;

    int tests_run;
    int tests_failed;
    int abort_cnt;
    int abort_base;

    serial_byte_collector_if #(.WIDTH(8)) out_if ();

    serial_byte_collector #(.WIDTH(8)) dut (
        .Clock       (Clock),
        .reset       (reset),
        .start       (start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .clr_overrun (clr_overrun),
        .busy        (busy),
        .overrun     (overrun),
        .frame_abort (frame_abort),
        .out_if      (out_if.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are settled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
        if (frame_abort === 1'b1) abort_cnt++;
    endtask

    task automatic send_bits(input logic [7:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bit_valid = 1'b1;
            bit_in    = w[i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic frame(input logic [7:0] w);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(w, 0, 7);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        abort_cnt    = 0;
        reset        = 1'b1;
        start        = 1'b0;
        bit_in       = 1'b0;
        bit_valid    = 1'b0;
        clr_overrun  = 1'b0;
        out_if.out_ready = 1'b0;

        tick();
        tick();
        check("rst_data",   {24'd0, out_if.out_data}, 32'h00);
        check("rst_valid",  {31'd0, out_if.out_valid}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_ovr",    {31'd0, overrun}, 32'd0);
        check("rst_abort",  {31'd0, frame_abort}, 32'd0);
        reset = 1'b0;

        // bit_valid in IDLE is ignored
        for (int i = 0; i < 4; i++) begin
            bit_valid = i[0];
            bit_in    = 1'b1;
            tick();
            check("idle_busy",  {31'd0, busy}, 32'd0);
            check("idle_valid", {31'd0, out_if.out_valid}, 32'd0);
        end
        bit_valid = 1'b0;

        // complemented 0x05 -> 0xFB with consumer ready
        out_if.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        send_bits(8'hFB, 0, 6);
        check("pre_valid",  {31'd0, out_if.out_valid}, 32'd0);
        send_bits(8'hFB, 7, 7);
        check("fb_data",    {24'd0, out_if.out_data}, 32'hFB);
        check("fb_valid",   {31'd0, out_if.out_valid}, 32'd1);
        check("fb_busy",    {31'd0, busy}, 32'd0);
        tick();
        check("fb_consumed", {31'd0, out_if.out_valid}, 32'd0);
        check("fb_hold",    {24'd0, out_if.out_data}, 32'hFB);

        // overrun with consumer stalled
        out_if.out_ready = 1'b0;
        frame(8'hFB);
        check("ov1_valid",  {31'd0, out_if.out_valid}, 32'd1);
        frame(8'h01);
        check("ov_data",    {24'd0, out_if.out_data}, 32'hFB);
        check("ov_set",     {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ov_clr",     {31'd0, overrun}, 32'd0);
        // set and clear in the same cycle: set wins
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(8'h0F, 0, 6);
        clr_overrun = 1'b1;
        send_bits(8'h0F, 7, 7);
        clr_overrun = 1'b0;
        check("ov_set_wins", {31'd0, overrun}, 32'd1);
        check("ov_data2",   {24'd0, out_if.out_data}, 32'hFB);
        clr_overrun = 1'b1;
        out_if.out_ready = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ov_clr2",    {31'd0, overrun}, 32'd0);
        check("ov_drain",   {31'd0, out_if.out_valid}, 32'd0);

        // completion while previous word is being consumed
        out_if.out_ready = 1'b0;
        frame(8'h3C);
        check("bb_first",   {24'd0, out_if.out_data}, 32'h3C);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(8'hC3, 0, 6);
        check("bb_stable",  {24'd0, out_if.out_data}, 32'h3C);
        out_if.out_ready = 1'b1;
        send_bits(8'hC3, 7, 7);
        check("bb_valid",   {31'd0, out_if.out_valid}, 32'd1);
        check("bb_data",    {24'd0, out_if.out_data}, 32'hC3);
        check("bb_ovr",     {31'd0, overrun}, 32'd0);
        tick();
        check("bb_drain",   {31'd0, out_if.out_valid}, 32'd0);

        // restart after 3 bits, then 0x80
        abort_base = abort_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(8'h07, 0, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_pulse",   {31'd0, frame_abort}, 32'd1);
        check("ab_novalid", {31'd0, out_if.out_valid}, 32'd0);
        send_bits(8'h80, 0, 0);
        check("ab_oneshot", {31'd0, frame_abort}, 32'd0);
        send_bits(8'h80, 1, 6);
        check("ab_nopart",  {31'd0, out_if.out_valid}, 32'd0);
        send_bits(8'h80, 7, 7);
        check("ab_data",    {24'd0, out_if.out_data}, 32'h80);
        check("ab_count",   abort_cnt - abort_base, 32'd1);
        tick();

        // restart with bit on the completing cycle; that bit becomes bit 0
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(8'h7F, 0, 6);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        check("rw_abort",   {31'd0, frame_abort}, 32'd1);
        check("rw_novalid", {31'd0, out_if.out_valid}, 32'd0);
        check("rw_busy",    {31'd0, busy}, 32'd1);
        send_bits(8'h5B, 1, 7);
        check("rw_data",    {24'd0, out_if.out_data}, 32'h5B);
        check("rw_valid",   {31'd0, out_if.out_valid}, 32'd1);

        // reset mid-frame overrides every input
        abort_base = abort_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(8'h1F, 0, 4);
        reset       = 1'b1;
        start       = 1'b1;
        bit_valid   = 1'b1;
        bit_in      = 1'b1;
        clr_overrun = 1'b1;
        tick();
        check("mr_data",    {24'd0, out_if.out_data}, 32'h00);
        check("mr_valid",   {31'd0, out_if.out_valid}, 32'd0);
        check("mr_busy",    {31'd0, busy}, 32'd0);
        check("mr_ovr",     {31'd0, overrun}, 32'd0);
        check("mr_abort",   {31'd0, frame_abort}, 32'd0);
        reset       = 1'b0;
        start       = 1'b0;
        bit_valid   = 1'b0;
        clr_overrun = 1'b0;
        frame(8'hA5);
        check("mr_a5",      {24'd0, out_if.out_data}, 32'hA5);
        check("mr_a5_valid", {31'd0, out_if.out_valid}, 32'd1);
        check("mr_noabort", abort_cnt - abort_base, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_byte_collector.md
SERIAL_BYTE_COLLECTOR -- requirements
Module: serial_byte_collector

Interface
REQ-001 Parameter: WIDTH, 8, number of serial bits per word (≥2).
REQ-002 Clock  input  1  rising-edge clock; all state changes on its positive edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  frame-start strobe; (re)arms collection at bit 0.
REQ-005 bit_in  input  1  serial data bit, LSB first, from upstream serial complementer output y.
REQ-006 bit_valid  input  1  qualifies bit_in for one cycle; driven by the same strobe as upstream shift_control.
REQ-007 out_data  output  WIDTH  assembled word.
REQ-008 out_valid  output  1  out_data holds an unconsumed word.
REQ-009 out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-010 busy  output  1  high while in COLLECT.
REQ-011 overrun  output  1  sticky: a completed word was dropped.
REQ-012 clr_overrun  input  1  clears overrun.
REQ-013 frame_abort  output  1  one-cycle pulse: partial word discarded by a restart.

Function
REQ-014 States: IDLE, COLLECT; bit_valid in IDLE is ignored.
REQ-015 start in either state: bit count := 0, state := COLLECT, shift register kept (contents don't-care).
REQ-016 start with bit_valid in the same cycle: that bit is captured as bit 0.
REQ-017 COLLECT with bit_valid: shift register := {bit_in, shreg[WIDTH-1:1]}; count += 1.
REQ-018 Word completes on the bit_valid that occurs with count = WIDTH-1; state := IDLE, count := 0.
REQ-019 Completion with out_valid low, or with out_valid and out_ready both high: out_data := {bit_in, shreg[WIDTH-1:1]} and out_valid := 1 the next cycle (1-cycle latency from last bit).
REQ-020 Completion with out_valid high and out_ready low: new word dropped, out_data unchanged, overrun := 1.
REQ-021 out_valid and out_ready high with no completion: out_valid := 0 the next cycle; out_data holds.
REQ-022 out_data stays stable while out_valid is high and out_ready is low.
REQ-023 start in COLLECT with count ≠ 0: frame_abort pulses high for exactly one cycle; no partial word reaches out_data.
REQ-024 start in COLLECT on the cycle that would complete a word: restart wins; the word is discarded and frame_abort pulses.
REQ-025 overrun is cleared by clr_overrun; a set event in the same cycle as clr_overrun wins (overrun stays 1).
REQ-026 busy = (state == COLLECT), registered.
REQ-027 Count width: clog2(WIDTH) bits; no wrap beyond WIDTH-1.

Reset
REQ-028 When reset is high at a Clock edge: state := IDLE, count := 0, shreg := 0, out_data := 0, out_valid := 0, overrun := 0, frame_abort := 0, busy := 0.
REQ-029 reset overrides start, bit_valid, out_ready and clr_overrun in the same cycle.
REQ-030 reset mid-frame discards the partial word without pulsing frame_abort.

Structure
REQ-031 Shared package serial_pkg holds the state enum (IDLE, COLLECT) and the default WIDTH constant.
REQ-032 Single module; no sub-modules.

Verification
REQ-033 Upstream word 0x05 complemented, bits 1,1,0,1,1,1,1,1 after start, out_ready=1 -> out_data=0xFB, out_valid high one cycle after the 8th bit, then low.
REQ-034 Two frames 0xFB then 0x01 with out_ready=0 throughout -> out_data stays 0xFB, overrun=1; clr_overrun pulse -> overrun=0.
REQ-035 start, 3 bits, start again, then 8 bits of 0x80 -> one frame_abort pulse, out_data=0x80, no 0x?? partial word.
REQ-036 out_valid high, next word completes with out_ready=1 in the same cycle -> out_valid stays 1, out_data updates to the new word, overrun=0.
REQ-037 reset asserted after 5 bits, then 8-bit frame 0xA5 -> all outputs 0 during reset, then out_data=0xA5, frame_abort never pulses.
REQ-038 bit_valid toggling in IDLE with no start -> no shift, out_valid stays 0, busy stays 0.
